// File: rtl/irq_bus_if.sv
// Register-window bus between the CPU-side bus decoder and the interrupt controller.
// Protocol: every clock is a bus cycle. With we=1 the addressed register takes dbw at
// the edge. With we=0, dbr shows reg[addr] one cycle later. There is no valid/ready
// pair, so a transfer always completes in the cycle it is issued.
interface irq_bus_if;
  logic [7:0] dbr;
  logic [7:0] dbw;
  logic [1:0] addr;
  logic       we;

  modport master (input dbr, output dbw, output addr, output we);
  modport slave  (output dbr, input dbw, input addr, input we);
endinterface

// File: rtl/irq_ctrl.sv
// 8-source interrupt controller: pending latches with per-source mask and
// level/edge mode, a registered active-low IRQ, and a PEND/MASK/MODE/VEC window.
module irq_ctrl #(
  parameter int NSRC = 8,
  parameter int SYNC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  irq_bus_if.slave        bus,
  input  logic [NSRC-1:0] src,
  output logic            irq_n
);

  localparam logic [7:0] IMPL = 8'((9'd1 << NSRC) - 9'd1);

  logic [NSRC-1:0] s;
  logic [7:0]      s8;
  logic [7:0]      pend, mask, mode, src_prev;
  logic [7:0]      set_bits, clr_bits, soft_bits, pend_nxt;
  logic [7:0]      pm, vec, rd_val;
  logic [2:0]      idx;

  generate
    if (SYNC == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [NSRC-1:0] sync_q [SYNC];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= src;
          for (int i = 1; i < SYNC; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC-1];
    end
  endgenerate

  always_comb begin
    s8 = '0;
    s8[NSRC-1:0] = s;
  end

  always_comb begin
    // Edge detect uses src_prev, which tracks in both modes so a mode switch never fakes an edge.
    set_bits  = ((mode & s8 & ~src_prev) | (~mode & s8)) & IMPL;
    clr_bits  = (bus.we && bus.addr == 2'd0) ? bus.dbw : 8'h00;
    soft_bits = 8'h00;
    if (bus.we && bus.addr == 2'd3 && bus.dbw[7]) soft_bits[bus.dbw[2:0]] = 1'b1;
    // Set terms are ORed after the clear so a same-cycle request is never lost.
    pend_nxt  = ((pend & ~clr_bits) | set_bits | soft_bits) & IMPL;
  end

  always_comb begin
    pm  = pend & mask;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pm[i]) idx = 3'(i);
    end
    vec = {|pm, 4'b0000, idx};
    case (bus.addr)
      2'd0:    rd_val = pend;
      2'd1:    rd_val = mask;
      2'd2:    rd_val = mode;
      default: rd_val = vec;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 8'h00;
      mask     <= 8'h00;
      mode     <= 8'h00;
      src_prev <= 8'h00;
      irq_n    <= 1'b1;
      bus.dbr  <= 8'h00;
    end else begin
      pend     <= pend_nxt;
      src_prev <= s8;
      irq_n    <= ~|(pend & mask);
      if (bus.we && bus.addr == 2'd1) mask <= bus.dbw & IMPL;
      if (bus.we && bus.addr == 2'd2) mode <= bus.dbw & IMPL;
      if (!bus.we) bus.dbr <= rd_val;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl (NSRC=8 and NSRC=4 instances side by side)
// against a per-cycle behavioural model feeding an expected-response queue.
module tb_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] src;
  logic [3:0] src4;
  logic       irq_n;
  logic       irq4_n;
  logic [7:0] src_v;

  irq_bus_if bus ();
  irq_bus_if bus4 ();

  assign bus4.we   = bus.we;
  assign bus4.addr = bus.addr;
  assign bus4.dbw  = bus.dbw;

  irq_ctrl #(.NSRC(8), .SYNC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .src(src), .irq_n(irq_n)
  );

  irq_ctrl #(.NSRC(4), .SYNC(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .src(src4), .irq_n(irq4_n)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // reference model: {irq_n, dbr} expected after each edge
  logic [8:0] exp_q[$];
  logic [8:0] exp4_q[$];
  logic [7:0] m_pend[2], m_mask[2], m_mode[2], m_prev[2], m_dbr[2];
  logic [7:0] m_impl[2];

  function automatic logic [7:0] vec_of(input logic [7:0] p);
    int i = 0;
    while (i < 8 && !p[i]) i++;
    if (i == 8) return 8'h00;
    return 8'h80 | 8'(i);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_mask[k] = 0; m_mode[k] = 0; m_prev[k] = 0; m_dbr[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input logic w, input logic [1:0] a,
                            input logic [7:0] d, input logic [7:0] s);
    logic [7:0] im, sv, pm, rd, nxt;
    logic [8:0] e;
    im = m_impl[k];
    sv = s & im;
    pm = m_pend[k] & m_mask[k];
    case (a)
      2'd0:    rd = m_pend[k];
      2'd1:    rd = m_mask[k];
      2'd2:    rd = m_mode[k];
      default: rd = vec_of(pm);
    endcase
    if (!w) m_dbr[k] = rd;
    e = {(pm == 8'h00), m_dbr[k]};
    if (k == 0) exp_q.push_back(e); else exp4_q.push_back(e);
    nxt = m_pend[k];
    if (w && a == 2'd0) nxt = nxt & ~d;
    for (int i = 0; i < 8; i++) begin
      if (m_mode[k][i] ? (sv[i] && !m_prev[k][i]) : sv[i]) nxt[i] = 1'b1;
    end
    if (w && a == 2'd3 && d[7]) nxt[d[2:0]] = 1'b1;
    m_pend[k] = nxt & im;
    if (w && a == 2'd1) m_mask[k] = d & im;
    if (w && a == 2'd2) m_mode[k] = d & im;
    m_prev[k] = sv;
  endtask

  // driver tasks
  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d);
    bus.we   = w;
    bus.addr = a;
    bus.dbw  = d;
    src      = src_v;
    src4     = src_v[3:0];
    @(posedge clk);
    model_edge(0, w, a, d, src_v);
    model_edge(1, w, a, d, src_v);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00);
  endtask

  task automatic read_const(input string name, input logic [1:0] a, input logic [7:0] exp);
    step(1'b0, a, 8'h00);
    check(name, bus.dbr, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("reset_irq_n", {7'b0, irq_n}, 8'h01);
    check("reset_dbr", bus.dbr, 8'h00);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("u8_irq_n", {7'b0, irq_n}, {7'b0, e[8]});
      check("u8_dbr", bus.dbr, e[7:0]);
    end
    if (exp4_q.size() > 0) begin
      e = exp4_q.pop_front();
      check("u4_irq_n", {7'b0, irq4_n}, {7'b0, e[8]});
      check("u4_dbr", bus4.dbr, e[7:0]);
    end
  end

  initial begin
    m_impl[0] = 8'hFF;
    m_impl[1] = 8'h0F;
    model_reset();
    rst_n = 1'b0;
    src_v = 8'h00;
    src = 8'h00;
    src4 = 4'h0;
    bus.we = 1'b0;
    bus.addr = 2'd0;
    bus.dbw = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: reset mid-operation with everything pending and enabled
    wr(2'd1, 8'hFF);
    for (int i = 0; i < 8; i++) wr(2'd3, 8'h80 | 8'(i));
    idle(2);
    check("t1_irq_before_reset", {7'b0, irq_n}, 8'h00);
    do_reset();
    read_const("t1_pend", 2'd0, 8'h00);
    read_const("t1_mask", 2'd1, 8'h00);
    read_const("t1_mode", 2'd2, 8'h00);
    read_const("t1_vec", 2'd3, 8'h00);
    check("t1_irq_n", {7'b0, irq_n}, 8'h01);

    // 2: level source with W1C while still asserted
    wr(2'd1, 8'h01);
    src_v = 8'h01;
    idle(2);
    check("t2_irq_low", {7'b0, irq_n}, 8'h00);
    read_const("t2_vec", 2'd3, 8'h80);
    wr(2'd0, 8'h01);
    read_const("t2_pend_reset", 2'd0, 8'h01);
    src_v = 8'h00;
    wr(2'd0, 8'h01);
    idle(2);
    check("t2_irq_high", {7'b0, irq_n}, 8'h01);

    // 3: edge mode pulse, then held high gives no re-set
    wr(2'd2, 8'h08);
    wr(2'd1, 8'h08);
    src_v = 8'h08;
    idle(1);
    src_v = 8'h00;
    idle(1);
    read_const("t3_pend", 2'd0, 8'h08);
    read_const("t3_vec", 2'd3, 8'h83);
    check("t3_irq_low", {7'b0, irq_n}, 8'h00);
    src_v = 8'h08;
    idle(1);
    wr(2'd0, 8'h08);
    idle(3);
    read_const("t3_no_reset", 2'd0, 8'h00);

    // 4: priority and masking
    src_v = 8'h00;
    wr(2'd2, 8'h00);
    wr(2'd0, 8'hFF);
    wr(2'd3, 8'h85);
    wr(2'd3, 8'h82);
    wr(2'd1, 8'hFF);
    read_const("t4_vec_ff", 2'd3, 8'h82);
    wr(2'd1, 8'h20);
    read_const("t4_vec_20", 2'd3, 8'h85);
    wr(2'd1, 8'h00);
    idle(1);
    read_const("t4_vec_00", 2'd3, 8'h00);
    check("t4_irq_high", {7'b0, irq_n}, 8'h01);
    read_const("t4_pend", 2'd0, 8'h24);

    // 5: W1C collides with a rising edge on the same bit
    wr(2'd0, 8'hFF);
    wr(2'd2, 8'h02);
    idle(1);
    src_v = 8'h02;
    wr(2'd0, 8'h02);
    read_const("t5_pend", 2'd0, 8'h02);

    // 6: software trigger, no-op VEC write, unimplemented bit on NSRC=4
    src_v = 8'h00;
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h40);
    wr(2'd3, 8'h86);
    idle(1);
    read_const("t6_pend", 2'd0, 8'h40);
    check("t6_u4_pend", bus4.dbr, 8'h00);
    check("t6_irq_low", {7'b0, irq_n}, 8'h00);
    wr(2'd0, 8'h40);
    wr(2'd3, 8'h06);
    idle(1);
    read_const("t6_noop", 2'd0, 8'h00);

    // randomised traffic with occasional resets
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] d;
      if ($urandom_range(0, 3) == 0) src_v = 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) step(1'b1, 2'($urandom_range(0, 3)), d);
      else step(1'b0, 2'($urandom_range(0, 3)), d);
      if (n % 500 == 499) do_reset();
    end

    src_v = 8'h00;
    idle(2);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
